instruction_encoder: RTL and testbench

Streaming RISC-V RV32I instruction encoder and program loader; the inverse of the decode-side immediate generation path. It accepts decoded instruction fields (opcode, registers, funct fields, 32-bit immediate) over a valid/ready handshake and range-checks the immediate. It scatters the immediate into the format-specific bit positions and writes the packed 32-bit word into instruction memory at sequential word addresses. It sits between the testbench/boot host and the instruction memory write port.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/imm_packer.sv | 67 ++++++
 rtl/instruction_encoder.sv | 149 ++++++++++++++
 tb/tb_instruction_encoder.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// RV32I opcode constants, the canonical NOP and the loader FSM state type shared by the
// instruction encoder and its immediate packer.
package riscv_pkg;

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDrain
   } loader_state_e;

   // True when value is representable as a two's-complement number of the given width.
   function automatic logic fits_signed(input logic [31:0] value, input int unsigned width);
      logic [31:0] upper;
      upper = $signed(value) >>> (width - 1);
      return (upper == '0) || (upper == '1);
   endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational RV32I field packer: scatters the immediate into its format-specific bit
// positions and flags illegal opcodes or immediates that the decoder could not reproduce.
module imm_packer
   import riscv_pkg::*;
(
   input  logic [4:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        legal
);

   logic        is_shift;
   logic [31:0] word;
   logic        ok;

   always_comb begin
      word     = NOP_INSTR;
      ok       = 1'b0;
      // SLLI/SRLI/SRAI reuse the I-format slot for funct7 and a 5-bit shamt.
      is_shift = (opcode == OPC_OP_IMM) && (funct3[1:0] == 2'b01);

      case (opcode)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            if (is_shift) begin
               word = {funct7, imm[4:0], rs1, funct3, rd, opcode, 2'b11};
               ok   = (imm[31:5] == '0);
            end else begin
               word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
               ok   = fits_signed(imm, 12);
            end
         end
         OPC_STORE: begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
            ok   = fits_signed(imm, 12);
         end
         OPC_BRANCH: begin
            word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
            ok   = fits_signed(imm, 13) && !imm[0];
         end
         OPC_JAL: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
            ok   = fits_signed(imm, 21) && !imm[0];
         end
         OPC_AUIPC, OPC_LUI: begin
            word = {imm[31:12], rd, opcode, 2'b11};
            ok   = (imm[11:0] == '0);
         end
         OPC_OP: begin
            word = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
            ok   = 1'b1;
         end
         default: begin
            word = NOP_INSTR;
            ok   = 1'b0;
         end
      endcase

      instr = ok ? word : NOP_INSTR;
      legal = ok;
   end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I program loader: accepts decoded field bundles, packs them into 32-bit
// words and writes them to sequential instruction-memory addresses.
module instruction_encoder
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   num_instr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            in_opcode,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [31:0]           in_imm,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] err_index
);

   localparam logic [ADDR_WIDTH:0]   MaxCount = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CountOne = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] AddrOne  = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

   loader_state_e         state_q, state_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] err_index_q, err_index_d;

   logic        xfer;
   logic [31:0] packed_instr;
   logic        packed_legal;

   imm_packer u_imm_packer (
      .opcode (in_opcode),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .imm    (in_imm),
      .instr  (packed_instr),
      .legal  (packed_legal)
   );

   assign in_ready = (state_q == StLoad) && (remaining_q != '0);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      done_d      = 1'b0;
      err_d       = err_q;
      err_index_d = err_index_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StLoad;
               remaining_d = (num_instr > MaxCount) ? MaxCount : num_instr;
               addr_d      = '0;
               err_d       = 1'b0;
               err_index_d = '0;
            end
         end
         StLoad: begin
            if (remaining_q == '0) begin
               // Empty load: done lands one cycle after entry with no write.
               state_d = StDrain;
               done_d  = 1'b1;
            end else if (xfer) begin
               we_d        = 1'b1;
               waddr_d     = addr_q;
               wdata_d     = packed_instr;
               addr_d      = addr_q + AddrOne;
               remaining_d = remaining_q - CountOne;
               if (!packed_legal) begin
                  err_d = 1'b1;
                  if (!err_q) begin
                     err_index_d = addr_q;
                  end
               end
               // done is registered alongside the final write so both appear together.
               if (remaining_q == CountOne) begin
                  state_d = StDrain;
                  done_d  = 1'b1;
               end
            end
         end
         StDrain: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_index_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_index_q <= err_index_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = waddr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign err       = err_q;
   assign err_index = err_index_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed program loads plus randomized
// bundles compared against an arithmetic reference encoder and a decode round-trip.
module tb_instruction_encoder;
   import riscv_pkg::*;

   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      logic [4:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } bundle_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   num_instr = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4:0]    in_opcode = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]    in_funct3 = '0;
   logic [6:0]    in_funct7 = '0;
   logic [31:0]   in_imm = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          busy, done, err;
   logic [AW-1:0] err_index;

   int n_tests = 0;
   int n_fail  = 0;

   bundle_t       bq[$];
   logic [AW-1:0] wa[$];
   logic [31:0]   wd[$];
   int            done_cnt = 0;

   logic [4:0]  opc_pool [0:10] = '{OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
                                    OPC_JAL, OPC_AUIPC, OPC_LUI, OPC_OP, 5'b11100, 5'b00011};
   logic [31:0] imm_edges [0:17] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'd31, 32'd32, 32'h7FF,
                                     32'h800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFE, 32'hFFF,
                                     32'hFFFF_F000, 32'hFFFF_EFFE, 32'h000F_FFFE,
                                     32'h0010_0000, 32'hFFF0_0000, 32'hFFEF_FFFE,
                                     32'h1234_5000};

   always #5 clk = ~clk;

   instruction_encoder #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_instr (num_instr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_index (err_index)
   );

   // Memory-side monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
      if (done) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit model_legal(input bundle_t b);
      longint s;
      s = longint'($signed(b.imm));
      case (b.opc)
         OPC_OP_IMM: begin
            if (b.f3 == 3'd1 || b.f3 == 3'd5) return (s >= 0) && (s <= 31);
            return (s >= -2048) && (s <= 2047);
         end
         OPC_LOAD, OPC_JALR, OPC_STORE: return (s >= -2048) && (s <= 2047);
         OPC_BRANCH: return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
         OPC_JAL:    return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
         OPC_AUIPC, OPC_LUI: return (b.imm % 4096) == 0;
         OPC_OP:     return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_word(input bundle_t b);
      logic [31:0] u, op, rdf, rs1f, rs2f, f3f, f7f;
      if (!model_legal(b)) return NOP_INSTR;
      u    = b.imm;
      op   = {25'd0, b.opc, 2'b11};
      rdf  = 32'(b.rd) * 128;
      rs1f = 32'(b.rs1) * 32768;
      rs2f = 32'(b.rs2) * 1048576;
      f3f  = 32'(b.f3) * 4096;
      f7f  = 32'(b.f7) * 33554432;
      case (b.opc)
         OPC_STORE:  return (((u >> 5) % 128) << 25) | rs2f | rs1f | f3f | ((u % 32) << 7) | op;
         OPC_BRANCH: return (((u >> 12) % 2) << 31) | (((u >> 5) % 64) << 25) | rs2f | rs1f
                            | f3f | (((u >> 1) % 16) << 8) | (((u >> 11) % 2) << 7) | op;
         OPC_JAL:    return (((u >> 20) % 2) << 31) | (((u >> 1) % 1024) << 21)
                            | (((u >> 11) % 2) << 20) | (((u >> 12) % 256) << 12) | rdf | op;
         OPC_AUIPC, OPC_LUI: return u | rdf | op;
         OPC_OP:     return f7f | rs2f | rs1f | f3f | rdf | op;
         default: begin
            if (b.opc == OPC_OP_IMM && (b.f3 == 3'd1 || b.f3 == 3'd5))
               return f7f | ((u % 32) << 20) | rs1f | f3f | rdf | op;
            return ((u % 4096) << 20) | rs1f | f3f | rdf | op;
         end
      endcase
   endfunction

   // Decode-side immediate generator, used to check the round-trip property.
   function automatic logic [31:0] decode_imm(input logic [31:0] w);
      case (w[6:2])
         OPC_STORE:  return {{20{w[31]}}, w[31:25], w[11:7]};
         OPC_BRANCH: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         OPC_JAL:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         OPC_AUIPC, OPC_LUI: return {w[31:12], 12'b0};
         OPC_OP_IMM: begin
            if (w[13:12] == 2'b01) return {27'd0, w[24:20]};
            return {{20{w[31]}}, w[31:20]};
         end
         default:    return {{20{w[31]}}, w[31:20]};
      endcase
   endfunction

   function automatic bundle_t mk(input logic [4:0] opc, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] f3, input logic [31:0] imm);
      bundle_t b;
      b.opc = opc; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = '0; b.imm = imm;
      return b;
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b.opc = opc_pool[$urandom_range(10)];
      b.rd  = 5'($urandom);
      b.rs1 = 5'($urandom);
      b.rs2 = 5'($urandom);
      b.f3  = 3'($urandom);
      b.f7  = 7'($urandom);
      case ($urandom_range(3))
         0:       b.imm = imm_edges[$urandom_range(17)];
         1:       b.imm = 32'($urandom_range(8191)) - 32'd4096;
         2:       b.imm = $urandom & 32'hFFFF_F000;
         default: b.imm = $urandom;
      endcase
      return b;
   endfunction

   // ---------------- stimulus plumbing (no checking here) ----------------
   task automatic drive_fields(input bundle_t b);
      in_opcode = b.opc; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
      in_funct3 = b.f3;  in_funct7 = b.f7; in_imm = b.imm;
   endtask

   // Runs one load of bq from posedge+1 and returns the observed handshake/completion timing.
   task automatic do_load(input int n_cfg, input int gap_pct, input bit poke,
                          output int iters, output bit timed_out, output int done_cyc,
                          output bit we_at_done, output bit busy_after);
      int exp_n, idx;
      bit xfer;
      exp_n = (n_cfg > DEPTH) ? DEPTH : n_cfg;
      wa.delete(); wd.delete(); done_cnt = 0;
      start = 1'b1; num_instr = n_cfg[AW:0];
      @(posedge clk); #1;
      start = 1'b0; idx = 0; iters = 0; timed_out = 1'b0;
      while (idx < exp_n && !timed_out) begin
         in_valid = ($urandom_range(99) >= gap_pct);
         drive_fields(bq[idx]);
         start = poke && (idx == exp_n / 2);
         @(negedge clk);
         xfer = in_valid && in_ready;
         @(posedge clk); #1;
         if (xfer) idx++;
         iters++;
         if (iters > 8 * exp_n + 32) timed_out = 1'b1;
      end
      in_valid = 1'b0; start = 1'b0;
      done_cyc = -1; we_at_done = 1'b0;
      for (int c = 0; c < 6 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (done) begin done_cyc = c; we_at_done = mem_we; end
      end
      @(negedge clk);
      busy_after = busy;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
         $display("FAIL reset_flags: got rdy/we/busy/done/err=%b, expected 00000",
                  {in_ready, mem_we, busy, done, err});
         n_fail++;
      end
      n_tests++;
      if (mem_addr !== '0 || mem_wdata !== '0 || err_index !== '0) begin
         $display("FAIL reset_values: got addr=%h wdata=%h err_index=%h, expected 0",
                  mem_addr, mem_wdata, err_index);
         n_fail++;
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int it, dc; bit to, wdn, ba;
      logic [31:0] got;
      bq.delete();
      bq.push_back(mk(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF));
      bq.push_back(mk(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000));
      do_load(2, 0, 1'b0, it, to, dc, wdn, ba);
      got = (wd.size() > 0) ? wd[0] : 32'hxxxx_xxxx;
      n_tests++;
      if (got !== 32'hFFF0_0093 || wa.size() < 1 || wa[0] !== 8'd0) begin
         $display("FAIL addi: got %h, expected FFF00093 at addr 0", got); n_fail++;
      end
      got = (wd.size() > 1) ? wd[1] : 32'hxxxx_xxxx;
      n_tests++;
      if (got !== 32'h1234_52B7 || wa.size() < 2 || wa[1] !== 8'd1) begin
         $display("FAIL lui: got %h, expected 123452B7 at addr 1", got); n_fail++;
      end
      n_tests++;
      if (err !== 1'b0) begin $display("FAIL legal_err: got %b, expected 0", err); n_fail++; end

      bq.delete();
      bq.push_back(mk(OPC_STORE, 5'd0, 5'd3, 5'd2, 3'd2, 32'd8));
      bq.push_back(mk(OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC));
      do_load(2, 0, 1'b0, it, to, dc, wdn, ba);
      got = (wd.size() > 0) ? wd[0] : 32'hxxxx_xxxx;
      n_tests++;
      if (got !== 32'h0021_A423) begin
         $display("FAIL sw: got %h, expected 0021A423", got); n_fail++;
      end
      got = (wd.size() > 1) ? wd[1] : 32'hxxxx_xxxx;
      n_tests++;
      if (got !== 32'hFE00_0EE3) begin
         $display("FAIL beq: got %h, expected FE000EE3", got); n_fail++;
      end
   endtask

   task automatic test_illegal();
      int it, dc; bit to, wdn, ba;
      logic [31:0] got0, got1;
      bq.delete();
      bq.push_back(mk(OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3));
      bq.push_back(mk(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001));
      do_load(2, 0, 1'b0, it, to, dc, wdn, ba);
      got0 = (wd.size() > 0) ? wd[0] : 32'hxxxx_xxxx;
      got1 = (wd.size() > 1) ? wd[1] : 32'hxxxx_xxxx;
      n_tests++;
      if (got0 !== NOP_INSTR || got1 !== NOP_INSTR) begin
         $display("FAIL illegal_nop: got %h %h, expected 00000013 00000013", got0, got1);
         n_fail++;
      end
      n_tests++;
      if (err !== 1'b1 || err_index !== 8'd0) begin
         $display("FAIL illegal_err: got err=%b idx=%0d, expected err=1 idx=0", err, err_index);
         n_fail++;
      end

      bq.delete();
      bq.push_back(mk(OPC_OP_IMM, 5'd2, 5'd1, 5'd0, 3'd0, 32'd2047));
      bq.push_back(mk(OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFFFF_F800));
      bq.push_back(mk(OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFEF_FFFE));
      bq.push_back(mk(OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 32'hDEAD_BEEF));
      bq.push_back(mk(5'b11100, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0));
      do_load(5, 0, 1'b0, it, to, dc, wdn, ba);
      n_tests++;
      if (err !== 1'b1 || err_index !== 8'd2) begin
         $display("FAIL first_err_index: got err=%b idx=%0d, expected err=1 idx=2",
                  err, err_index);
         n_fail++;
      end
      got0 = (wd.size() > 3) ? wd[3] : 32'hxxxx_xxxx;
      got1 = (wd.size() > 4) ? wd[4] : 32'hxxxx_xxxx;
      n_tests++;
      if (got0 !== model_word(bq[3]) || got1 !== NOP_INSTR) begin
         $display("FAIL after_err: got %h %h, expected %h 00000013",
                  got0, got1, model_word(bq[3]));
         n_fail++;
      end
   endtask

   task automatic test_gaps();
      int it, dc, bad; bit to, wdn, ba;
      bq.delete();
      for (int i = 0; i < 4; i++) bq.push_back(rand_bundle());
      do_load(4, 50, 1'b1, it, to, dc, wdn, ba);
      n_tests++;
      if (to || wa.size() != 4) begin
         $display("FAIL gaps_count: got %0d writes (timeout=%0b), expected 4", wa.size(), to);
         n_fail++;
      end
      bad = 0;
      for (int i = 0; i < wa.size(); i++)
         if (i >= 4 || wa[i] !== i[AW-1:0] || wd[i] !== model_word(bq[i])) bad++;
      n_tests++;
      if (bad != 0) begin
         $display("FAIL gaps_writes: got %0d bad writes, expected 0", bad); n_fail++;
      end
      n_tests++;
      if (dc != 0 || !wdn || done_cnt != 1) begin
         $display("FAIL gaps_done: got done_cycle=%0d we_at_done=%b pulses=%0d, expected 0 1 1",
                  dc, wdn, done_cnt);
         n_fail++;
      end
      n_tests++;
      if (ba !== 1'b0) begin
         $display("FAIL gaps_busy_fall: got busy=%b after done, expected 0", ba); n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      bq.delete();
      for (int i = 0; i < 4; i++) bq.push_back(rand_bundle());
      start = 1'b1; num_instr = 9'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; drive_fields(bq[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_tests++;
      if (mem_we !== 1'b1 || mem_addr !== 8'd1 || busy !== 1'b1) begin
         $display("FAIL pre_reset_write: got we=%b addr=%0d busy=%b, expected 1 1 1",
                  mem_we, mem_addr, busy);
         n_fail++;
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== '0 ||
          mem_wdata !== '0 || err_index !== '0) begin
         $display("FAIL mid_reset: got rdy/we/busy/done/err=%b addr=%h wdata=%h idx=%h, expected 0",
                  {in_ready, mem_we, busy, done, err}, mem_addr, mem_wdata, err_index);
         n_fail++;
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero();
      int it, dc; bit to, wdn, ba;
      bq.delete();
      do_load(0, 0, 1'b0, it, to, dc, wdn, ba);
      n_tests++;
      if (dc != 1 || done_cnt != 1) begin
         $display("FAIL zero_done: got done_cycle=%0d pulses=%0d, expected 1 1", dc, done_cnt);
         n_fail++;
      end
      n_tests++;
      if (wa.size() != 0 || ba !== 1'b0) begin
         $display("FAIL zero_writes: got %0d writes busy_after=%b, expected 0 0", wa.size(), ba);
         n_fail++;
      end
   endtask

   task automatic test_random();
      int it, dc, n; bit to, wdn, ba, exp_err;
      logic [AW-1:0] exp_idx;
      for (int l = 0; l < 8; l++) begin
         n = $urandom_range(24, 1);
         bq.delete();
         for (int i = 0; i < n; i++) bq.push_back(rand_bundle());
         do_load(n, 30, 1'b0, it, to, dc, wdn, ba);
         n_tests++;
         if (to || wd.size() != n || dc != 0) begin
            $display("FAIL random_count: load %0d got %0d writes done_cycle=%0d timeout=%0b, expected %0d 0 0",
                     l, wd.size(), dc, to, n);
            n_fail++;
         end
         exp_err = 1'b0; exp_idx = '0;
         for (int i = 0; i < n; i++) begin
            if (!model_legal(bq[i]) && !exp_err) begin exp_err = 1'b1; exp_idx = i[AW-1:0]; end
         end
         for (int i = 0; i < n && i < wd.size(); i++) begin
            n_tests++;
            if (wa[i] !== i[AW-1:0] || wd[i] !== model_word(bq[i])) begin
               $display("FAIL random_word: load %0d slot %0d opc=%b imm=%h got %h@%0d, expected %h@%0d",
                        l, i, bq[i].opc, bq[i].imm, wd[i], wa[i], model_word(bq[i]), i);
               n_fail++;
            end
            if (model_legal(bq[i]) && bq[i].opc != OPC_OP) begin
               n_tests++;
               if (decode_imm(wd[i]) !== bq[i].imm) begin
                  $display("FAIL roundtrip: slot %0d word %h decodes to %h, expected %h",
                           i, wd[i], decode_imm(wd[i]), bq[i].imm);
                  n_fail++;
               end
            end
         end
         n_tests++;
         if (err !== exp_err || err_index !== exp_idx) begin
            $display("FAIL random_err: load %0d got err=%b idx=%0d, expected err=%b idx=%0d",
                     l, err, err_index, exp_err, exp_idx);
            n_fail++;
         end
      end
   endtask

   task automatic test_back_to_back();
      int it, dc, bad; bit to, wdn, ba, exp_err;
      logic [AW-1:0] exp_idx;
      bq.delete();
      for (int i = 0; i < 16; i++) bq.push_back(rand_bundle());
      do_load(16, 0, 1'b0, it, to, dc, wdn, ba);
      n_tests++;
      if (it != 16 || wa.size() != 16 || dc != 0) begin
         $display("FAIL throughput: got %0d cycles %0d writes done_cycle=%0d, expected 16 16 0",
                  it, wa.size(), dc);
         n_fail++;
      end

      bq.delete();
      for (int i = 0; i < DEPTH; i++) bq.push_back(rand_bundle());
      do_load(300, 0, 1'b0, it, to, dc, wdn, ba);
      n_tests++;
      if (it != DEPTH || wa.size() != DEPTH || done_cnt != 1) begin
         $display("FAIL saturate_count: got %0d cycles %0d writes %0d done, expected %0d %0d 1",
                  it, wa.size(), done_cnt, DEPTH, DEPTH);
         n_fail++;
      end
      bad = 0; exp_err = 1'b0; exp_idx = '0;
      for (int i = 0; i < wa.size(); i++) begin
         if (i >= DEPTH || wa[i] !== i[AW-1:0] || wd[i] !== model_word(bq[i])) bad++;
      end
      for (int i = 0; i < DEPTH; i++)
         if (!model_legal(bq[i]) && !exp_err) begin exp_err = 1'b1; exp_idx = i[AW-1:0]; end
      n_tests++;
      if (bad != 0) begin
         $display("FAIL saturate_writes: got %0d bad writes, expected 0", bad); n_fail++;
      end
      n_tests++;
      if (err !== exp_err || err_index !== exp_idx) begin
         $display("FAIL saturate_err: got err=%b idx=%0d, expected err=%b idx=%0d",
                  err, err_index, exp_err, exp_idx);
         n_fail++;
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_directed();
      test_illegal();
      test_gaps();
      test_reset_mid();
      test_zero();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
